// File: rtl/add_share_pkg.sv
// Shared types and defaults for the shared-adder arbiter: FSM encoding,
// default widths and a small modulo-increment helper.
package add_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEF_DATAWIDTH = 4;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_ID_W      = 2;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/add_share_arbiter_if.sv
// Request/response bundle between the issuing FSMs (master) and the shared
// adder arbiter (slave).
interface add_share_arbiter_if
  import add_share_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int ID_W      = DEF_ID_W
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATAWIDTH-1:0] req_a;
  logic [NUM_REQ*DATAWIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [DATAWIDTH-1:0]         rsp_sum;
  logic [ID_W-1:0]              rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id
  );
endinterface

// File: rtl/add.sv
// Combinational adder; the sum wraps modulo 2^DATAWIDTH and carry-out is dropped.
// Zero latency, no flow control.
module add #(
  parameter int DATAWIDTH = 4
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Zero latency; grant is empty when no request is set.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);
  logic [2*NUM_REQ-1:0] rot;
  int                   sel_off;
  int                   sel_abs;

  // Rotating a doubled vector puts requester ptr at bit 0, so a plain
  // lowest-set-bit search yields the round-robin winner.
  assign rot = {req, req} >> ptr;

  always_comb begin
    sel_off = 0;
    any     = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (rot[off]) begin
        sel_off = off;
        any     = 1'b1;
      end
    end
    sel_abs = int'(ptr) + sel_off;
    if (sel_abs >= NUM_REQ) begin
      sel_abs = sel_abs - NUM_REQ;
    end
    idx = ID_W'(sel_abs);
    gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = any && (idx == ID_W'(i));
    end
  end
endmodule

// File: rtl/add_share_arbiter.sv
// Round-robin sharing of one adder among NUM_REQ requesters; grant -> rsp_valid after 2 edges.
// Response held until rsp_ready; no new grant until it is accepted (min 3 cycles/op).
module add_share_arbiter
  import add_share_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int ID_W      = DEF_ID_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  add_share_arbiter_if.slave   bus,
  output logic                 busy
);
  state_e               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [DATAWIDTH-1:0] a_q, a_d;
  logic [DATAWIDTH-1:0] b_q, b_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATAWIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;

  logic [NUM_REQ-1:0]   win_gnt;
  logic [ID_W-1:0]      win_idx;
  logic                 win_any;
  logic [DATAWIDTH-1:0] add_sum;
  logic [NUM_REQ-1:0]   req_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req (bus.req_valid),
    .ptr (rr_ptr_q),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  add #(
    .DATAWIDTH (DATAWIDTH)
  ) u_add (
    .a   (a_q),
    .b   (b_q),
    .sum (add_sum)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
    req_ready   = '0;

    case (state_q)
      IDLE: begin
        // Gating with rst_n keeps every ready low while reset is held.
        if (win_any && rst_n) begin
          req_ready = win_gnt;
          id_d      = win_idx;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == ID_W'(i)) begin
              a_d = bus.req_a[i*DATAWIDTH +: DATAWIDTH];
              b_d = bus.req_b[i*DATAWIDTH +: DATAWIDTH];
            end
          end
          state_d = CALC;
        end
      end
      CALC: begin
        rsp_sum_d   = add_sum;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = ID_W'(wrap_inc(int'(rsp_id_q), NUM_REQ));
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = (state_q != IDLE);
endmodule
